dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MIPS CPU load/store port; the CPU core is the initiator and this block answers its requests.
- Accepts one word-aligned read or write request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or write completion, with an error flag, over a second valid/ready handshake.
- Replaces the zero-latency data memory so the CPU's stall path can be exercised in the CPU-level bench.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words stored; power of two, minimum 4.
WAIT_CYCLES, 2, wait states between request acceptance and response; 0 allowed.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
req_valid  input  1  CPU presents a request
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
rsp_valid  output  1  response available
rsp_ready  input  1  CPU accepts the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- States: IDLE, WAIT, RESP. Reset forces IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clears the wait counter.
- Memory array contents are not reset.
- IDLE: req_ready=1.
  - On req_valid & req_ready, latch we, addr, wdata and be.
  - If WAIT_CYCLES=0, go to RESP; otherwise load counter = WAIT_CYCLES-1 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle; when it reaches 0, go to RESP next cycle. A WAIT_CYCLES=N request spends exactly N cycles in WAIT.
- Memory access happens on the WAIT->RESP or IDLE->RESP transition edge:
  - Store: write enabled bytes only.
  - Load: register the full word into rsp_rdata; req_be is ignored for loads.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On the rsp_ready edge, return to IDLE with rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency: request accept edge to rsp_valid high is WAIT_CYCLES+1 cycles.
- Back-to-back requests: a new request is accepted at the earliest on the cycle after the response handshake, because req_ready rises in IDLE.
- No combinational path from req_valid to req_ready, or from rsp_ready to rsp_valid.
- Error conditions:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[31:2] >= DEPTH_WORDS.
  - Error requests take the full latency, set rsp_err=1 and rsp_rdata=0, and never write memory.
- Word index = addr[$clog2(DEPTH_WORDS)+1:2], used only when in range.
- Store with be=0000: completes normally with no memory change and rsp_err=0.
- Reset mid-transaction: the in-flight request is discarded and no response is issued. A store still in WAIT performs no write.
- Inputs req_* are ignored outside the IDLE accept handshake.

Optional Feature:
- Macro DMEM_ACCESS_COUNT_EN.
- When defined, two extra outputs are added:
  - rd_count [31:0]: counts completed successful loads.
  - wr_count [31:0]: counts completed successful stores.
  - Both increment on the response handshake edge, never for errors, reset to 0, and wrap from 0xFFFFFFFF to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg holds:
  - State encoding typedef dmem_state_t (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Constants WORD_BYTES=4 and ADDR_LSB=2.
- One sub-module, dmem_array: single-port word RAM with byte-enable write and registered read, parameterised by DEPTH_WORDS.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x10 with be=1111, then load 0x10 -> load response has rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid rises exactly 3 cycles after each accept (WAIT_CYCLES=2).
- Store 0x11223344 to 0x20 with be=1111, then store 0xAABBCCDD with be=0101, then load 0x20 -> rsp_rdata=0x11BB33DD.
- Load from 0x22, and load from 0x400 with DEPTH_WORDS=256 -> both give rsp_err=1, rsp_rdata=0; a following load from 0x20 is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0; on release, req_ready=1 the next cycle.
- Assert rst=0 during WAIT of a store to 0x30 that had prior value 0x5 -> outputs return to reset values, no response is issued, and a later load of 0x30 returns 0x5.
- With DMEM_ACCESS_COUNT_EN and WAIT_CYCLES=0: 3 good stores, 2 good loads, 1 misaligned load -> wr_count=3, rd_count=2, and each latency is 1 cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: state encoding and word-geometry constants used by dmem_responder
//          and dmem_array.
// Contents: dmem_state_t (IDLE/WAIT/RESP), WORD_BYTES, ADDR_LSB.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM with byte-enable write and registered read
//
// Purpose: storage behind dmem_responder. Contents are never reset.
// Ports:
//   clk    in   clock
//   en     in   access strobe (one access per asserted cycle)
//   we     in   1 = byte-enabled write, 0 = read into rdata
//   be     in   byte enables, bit i covers wdata[8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [WORD_BYTES-1:0]          be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder for the CPU load/store port
//
// Purpose: accepts one word request at a time, waits WAIT_CYCLES, then returns
//          load data or store completion with an error flag.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_be  request handshake
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                 response handshake
// Optional (DMEM_ACCESS_COUNT_EN): rd_count, wr_count successful-access counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t state, state_nx;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] cnt;
  logic        rsp_err_q;
  logic        rsp_load_q;
  logic [31:0] arr_rdata;

  logic        accept;
  logic        access;
  logic        handshake;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;

  assign accept    = (state == IDLE) && req_valid;
  assign handshake = (state == RESP) && rsp_ready;

  // With no wait states the access happens on the accept edge itself, so the
  // live request fields are used; otherwise the latched copy is.
  assign access    = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 32'd0));
  assign acc_we    = (WAIT_CYCLES == 0) ? req_we    : lat_we;
  assign acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : lat_addr;
  assign acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : lat_wdata;
  assign acc_be    = (WAIT_CYCLES == 0) ? req_be    : lat_be;

  assign acc_err = (acc_addr[ADDR_LSB-1:0] != '0) ||
                   ({2'b00, acc_addr[31:ADDR_LSB]} >= 32'(DEPTH_WORDS));

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (access && !acc_err),
    .we    (acc_we),
    .be    (acc_be),
    .addr  (acc_addr[AW+ADDR_LSB-1:ADDR_LSB]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 32'd0) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      cnt        <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        if (WAIT_CYCLES != 0) begin
          cnt <= 32'(WAIT_CYCLES - 1);
        end
      end
      if ((state == WAIT) && (cnt != 32'd0)) begin
        cnt <= cnt - 32'd1;
      end
      if (access) begin
        rsp_err_q  <= acc_err;
        rsp_load_q <= !acc_we && !acc_err;
      end
      if (handshake) begin
        rsp_err_q  <= 1'b0;
        rsp_load_q <= 1'b0;
      end
    end
  end

  // The RAM read register has no reset, so load data is only exposed while a
  // successful load response is pending.
  assign rsp_rdata = ((state == RESP) && rsp_load_q) ? arr_rdata : 32'd0;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (handshake && !rsp_err_q) begin
      if (lat_we) begin
        wr_count <= wr_count + 32'd1;
      end else begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`else
  // Access counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

`ifdef DMEM_ACCESS_COUNT_EN
  localparam int WC = 0;
`else
  localparam int WC = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    .rd_count  (rd_count),
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_rd_n = 0;
  int exp_wr_n = 0;

  logic [32:0] exp_q[$];
  int          acc_q[$];
  logic        seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency from accept edge to first response edge, and payload
  // against the scoreboard on each response handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (acc_q.size() == 0) begin
          chk("rsp_without_accept", 32'd1, 32'd0);
        end else begin
          chk("latency", 32'(cyc + 1 - acc_q.pop_front()), 32'(WC + 1));
        end
      end
      if (rsp_valid && rsp_ready) begin
        seen = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e[31:0]);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] er, input logic ee);
    int  i;
    logic done;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    exp_q.push_back({ee, er});
    if (!ee) begin
      if (we) exp_wr_n++;
      else    exp_rd_n++;
    end
    done = 1'b0;
    i = 0;
    while (!done && i < 50) begin
      if (req_ready) done = 1'b1;
      @(posedge clk); #1;
      i++;
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0BAD_0BAD;
    req_be    = 4'hF;
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] er, input logic ee);
    issue(we, addr, wdata, be, er, ee);
    wait_done();
  endtask

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b1;

    // basic store/load
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    xfer(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // byte-enable merge
    xfer(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    xfer(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0);
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);

    // errors never touch memory; 0x420 would alias word 8 if unchecked
    xfer(1'b0, 32'h22, 32'd0, 4'hF, 32'd0, 1'b1);
    xfer(1'b0, 32'h400, 32'd0, 4'hF, 32'd0, 1'b1);
    xfer(1'b1, 32'h21, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
    xfer(1'b1, 32'h420, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b1);
    xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
    xfer(1'b0, 32'h20, 32'd0, 4'h0, 32'h11BB_33DD, 1'b0);
    xfer(1'b0, 32'h3FC, 32'd0, 4'h0, 32'hxxxx_xxxx, 1'b0);
    xfer(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
    xfer(1'b0, 32'h3FC, 32'd0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // response back-pressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    i = 0;
    while (!rsp_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("hold_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    wait_done();
    @(posedge clk); #1;
    chk("post_release_req_ready", {31'd0, req_ready}, 32'd1);

`ifndef DMEM_ACCESS_COUNT_EN
    // reset while a store waits: no write, no response
    xfer(1'b1, 32'h30, 32'h5, 4'hF, 32'd0, 1'b0);
    issue(1'b1, 32'h30, 32'h99, 4'hF, 32'd0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    seen = 1'b0;
    exp_wr_n--;
    #1;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    xfer(1'b0, 32'h30, 32'd0, 4'h0, 32'h5, 1'b0);
`endif

`ifdef DMEM_ACCESS_COUNT_EN
    xfer(1'b1, 32'h40, 32'h1, 4'hF, 32'd0, 1'b0);
    xfer(1'b1, 32'h44, 32'h2, 4'hF, 32'd0, 1'b0);
    xfer(1'b1, 32'h48, 32'h3, 4'hF, 32'd0, 1'b0);
    xfer(1'b0, 32'h44, 32'd0, 4'h0, 32'h2, 1'b0);
    xfer(1'b0, 32'h48, 32'd0, 4'h0, 32'h3, 1'b0);
    xfer(1'b0, 32'h41, 32'd0, 4'h0, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("wr_count", wr_count, 32'(exp_wr_n));
    chk("rd_count", rd_count, 32'(exp_rd_n));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
